// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction prefetch stage |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  localparam int unsigned FETCH_ADDR_W  = 32;
  localparam int unsigned FETCH_INSTR_W = 32;
  localparam int unsigned PC_STEP       = FETCH_INSTR_W / 8;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc;
  } fetch_entry_t;

  function automatic int unsigned pc_step(input int unsigned instr_w);
    return instr_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_fifo : DEPTH-entry instruction/PC queue with push, pop and flush    |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module fetch_fifo #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] push_instr_i,
  input  logic [ADDR_W-1:0]  push_pc_i,
  input  logic               pop_i,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic [ADDR_W-1:0]  head_pc_o,
  output logic               empty_o,
  output logic               full_o,
  output logic [$clog2(DEPTH):0] count_next_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]     count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointers are PTR_W wide, so DEPTH being a power of two makes them wrap for free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push_i) begin
          instr_mem_q[wr_ptr_q] <= push_instr_i;
          pc_mem_q[wr_ptr_q]    <= push_pc_i;
          wr_ptr_q              <= wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  assign head_instr_o = instr_mem_q[rd_ptr_q];
  assign head_pc_o    = pc_mem_q[rd_ptr_q];
  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == FULL_CNT);
  assign count_next_o = count_d;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_queue : sequential instruction prefetch with redirect and queue.    |
// | Optional FETCH_BYPASS_EN forwards a response straight to decode when empty|
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               mem_req_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  input  logic               mem_rvalid_i,
  input  logic [INSTR_W-1:0] mem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  input  logic               instr_ready_i,
  output logic               busy_o
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(pc_step(INSTR_W));

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               discard_q, discard_d;
  logic               busy_q;

  logic               issue, accept, push, pop;
  logic               fifo_empty, fifo_full;
  logic [INSTR_W-1:0] head_instr;
  logic [ADDR_W-1:0]  head_pc;
  logic [$clog2(DEPTH):0] fifo_count_next;
  logic [ADDR_W-1:0]  redirect_pc_aligned;

  assign redirect_pc_aligned = redirect_pc_i & ~ADDR_W'(3);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    issue      = 1'b0;
    accept     = 1'b0;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_aligned;
      // A read still in flight must be absorbed before a new one may issue.
      if ((state_q == WAIT) && !mem_rvalid_i) begin
        discard_d = 1'b1;
      end else begin
        discard_d = 1'b0;
        state_d   = en_i ? REQ : IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (en_i) state_d = REQ;
        end
        REQ: begin
          if (!en_i) begin
            state_d = IDLE;
          end else if (!fifo_full) begin
            issue      = 1'b1;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + STEP;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            accept    = !discard_q;
            discard_d = 1'b0;
            state_d   = en_i ? REQ : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      discard_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
      busy_q     <= (state_d == WAIT) || (fifo_count_next != '0);
    end
  end

  assign mem_req_o  = issue;
  assign mem_addr_o = issue ? fetch_pc_q : '0;
  assign busy_o     = busy_q;
  assign pop        = !fifo_empty && instr_ready_i && !redirect_i;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass        = accept && fifo_empty;
  assign instr_valid_o = !fifo_empty || bypass;
  assign instr_o       = bypass ? mem_rdata_i : head_instr;
  assign instr_pc_o    = bypass ? req_pc_q : head_pc;
  assign push          = accept && !(bypass && instr_ready_i);
`else
  assign instr_valid_o = !fifo_empty;
  assign instr_o       = head_instr;
  assign instr_pc_o    = head_pc;
  assign push          = accept;
`endif

  fetch_fifo #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (redirect_i),
    .push_i       (push),
    .push_instr_i (mem_rdata_i),
    .push_pc_i    (req_pc_q),
    .pop_i        (pop),
    .head_instr_o (head_instr),
    .head_pc_o    (head_pc),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .count_next_o (fifo_count_next)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_queue : scoreboard bench for fetch_queue                         |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic          en          = 1'b0;
  logic          redirect    = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          mem_rvalid  = 1'b0;
  logic [IW-1:0] mem_rdata   = '0;
  logic          instr_ready = 1'b0;
  logic          mem_req, instr_valid, busy;
  logic [AW-1:0] mem_addr, instr_pc;
  logic [IW-1:0] instr;

  int n_checks  = 0;
  int n_fail    = 0;
  int mem_delay = 0;

  fetch_entry_t  exp_q[$];
  logic [AW-1:0] req_log[$];

  always #5 clk = ~clk;

  fetch_queue #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .DEPTH    (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_ready_i (instr_ready),
    .busy_o        (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] pc);
    fetch_entry_t e;
    e.instr = pc + 32'h100;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  function automatic logic [AW-1:0] get_req(input int i);
    if (req_log.size() > i) return req_log[i];
    return '1;
  endfunction

  task automatic do_reset();
    rst_n       = 1'b0;
    en          = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    mem_delay   = 0;
    repeat (8) tick();
    exp_q.delete();
    req_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string nm, input int max_cyc);
    int k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      tick();
      k++;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_req(input string nm, input logic [AW-1:0] addr, input int max_cyc);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < max_cyc) begin
      @(posedge clk);
      #2;
      seen = mem_req && (mem_addr == addr);
      k++;
    end
    chk(nm, 64'(seen), 64'd1);
  endtask

  // Memory: answers each request with data = addr + 0x100 after 1 + mem_delay cycles.
  initial begin : mem_model
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        a = mem_addr;
        req_log.push_back(a);
        repeat (mem_delay) @(posedge clk);
        @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        mem_rdata  = a + 32'h100;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
      end
    end
  end

  initial begin : monitor
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr: got pc %h instr %h, required no output", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          chk("instr", 64'(instr), 64'(e.instr));
          chk("instr_pc", 64'(instr_pc), 64'(e.pc));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int k;
    bit seen;

    // reset values
    repeat (3) tick();
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", 64'(instr_pc), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // sequential fetch, 1-cycle memory, decode always ready
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) push_exp(AW'(i * PC_STEP));
    en = 1'b1;
    wait_drain("p1_drain", 100);
    chk("p1_addr0", 64'(get_req(0)), 64'h0);
    chk("p1_addr1", 64'(get_req(1)), 64'h4);
    chk("p1_addr2", 64'(get_req(2)), 64'h8);
    en = 1'b0;
    instr_ready = 1'b0;

    // fill with decode stalled, then drain and resume
    do_reset();
    en = 1'b1;
    repeat (30) tick();
    #1;
    chk("p2_req_count", 64'(req_log.size()), 64'd4);
    chk("p2_mem_req_held", 64'(mem_req), 64'd0);
    chk("p2_valid_full", 64'(instr_valid), 64'd1);
    chk("p2_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 6; i++) push_exp(AW'(i * PC_STEP));
    instr_ready = 1'b1;
    wait_drain("p2_drain", 100);
    chk("p2_resume_addr", 64'(get_req(4)), 64'h10);
    en = 1'b0;
    instr_ready = 1'b0;

    // full queue with mixed push/pop traffic, order must hold
    do_reset();
    for (int i = 0; i < 10; i++) push_exp(AW'(i * PC_STEP));
    en = 1'b1;
    repeat (12) tick();
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      instr_ready = (k % 3 != 2);
      tick();
      k++;
    end
    chk("p3_drain", 64'(exp_q.size()), 64'd0);
    en = 1'b0;
    instr_ready = 1'b0;

    // redirect while the read of 0x8 is outstanding
    do_reset();
    mem_delay = 3;
    en = 1'b1;
    wait_req("p4_req8", 32'h8, 100);
    tick();
    chk("p4_valid_before", 64'(instr_valid), 64'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    #1;
    chk("p4_valid_flushed", 64'(instr_valid), 64'd0);
    chk("p4_no_req_while_stale", 64'(mem_req), 64'd0);
    push_exp(32'h200);
    push_exp(32'h204);
    instr_ready = 1'b1;
    wait_drain("p4_drain", 100);
    chk("p4_next_addr", 64'(get_req(3)), 64'h200);
    en = 1'b0;
    instr_ready = 1'b0;

    // redirect in the same cycle as the response for 0x8
    do_reset();
    en = 1'b1;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      @(posedge clk);
      #2;
      seen = mem_rvalid && (mem_rdata == 32'h108);
      k++;
    end
    chk("p5_rvalid8", 64'(seen), 64'd1);
    chk("p5_valid_before", 64'(instr_valid), 64'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    #1;
    chk("p5_req_next", 64'(mem_req), 64'd1);
    chk("p5_addr_next", 64'(mem_addr), 64'h200);
    chk("p5_valid_flushed", 64'(instr_valid), 64'd0);
    push_exp(32'h200);
    push_exp(32'h204);
    instr_ready = 1'b1;
    wait_drain("p5_drain", 100);
    en = 1'b0;
    instr_ready = 1'b0;

    // asynchronous reset in the middle of a wait
    do_reset();
    mem_delay = 3;
    en = 1'b1;
    wait_req("p6_req4", 32'h4, 100);
    tick();
    chk("p6_valid_before", 64'(instr_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("p6_mem_req", 64'(mem_req), 64'd0);
    chk("p6_mem_addr", 64'(mem_addr), 64'd0);
    chk("p6_instr_valid", 64'(instr_valid), 64'd0);
    chk("p6_instr", 64'(instr), 64'd0);
    chk("p6_instr_pc", 64'(instr_pc), 64'd0);
    chk("p6_busy", 64'(busy), 64'd0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("p6_late_rvalid_ignored", 64'(instr_valid), 64'd0);
    chk("p6_idle_busy", 64'(busy), 64'd0);
    mem_delay = 0;
    req_log.delete();
    push_exp(32'h0);
    instr_ready = 1'b1;
    en = 1'b1;
    wait_drain("p6_drain", 100);
    chk("p6_restart_addr", 64'(get_req(0)), 64'h0);
    en = 1'b0;
    instr_ready = 1'b0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction prefetch stage for the ARM7 core, sitting between instruction memory and decode. Keeps its own fetch PC, issues sequential word reads, and buffers returned instructions with their addresses in a DEPTH-entry FIFO drained by decode through a valid/ready handshake. A redirect (branch or PC write) flushes the queue and drops any stale in-flight read.

## Interface
- ADDR_W, 32, fetch address width
- INSTR_W, 32, instruction width; PC step is INSTR_W/8
- DEPTH, 4, queue entries; power of two, 2..16
- RESET_PC, 0, fetch PC after reset
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  fetching allowed; low stops new requests only
- redirect  in  1  flush and restart at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address; low 2 bits ignored (forced 0)
- mem_req  out  1  one-cycle read request pulse
- mem_addr  out  ADDR_W  request address, valid with mem_req
- mem_rvalid  in  1  read data valid, one cycle, at least 1 cycle after mem_req
- mem_rdata  in  INSTR_W  read data
- instr_valid  out  1  queue head valid
- instr  out  INSTR_W  head instruction
- instr_pc  out  ADDR_W  head address
- instr_ready  in  1  decode accepts head this cycle
- busy  out  1  request outstanding or queue non-empty

## Operation
- Reset: fetch_pc=RESET_PC, queue empty, state IDLE; mem_req, mem_addr, instr_valid, instr, instr_pc, busy all 0; discard flag 0.
- States: IDLE, REQ, WAIT.
- IDLE -> REQ when en=1.
- REQ: if en=0 -> IDLE. Else if count < DEPTH: assert mem_req, mem_addr=fetch_pc, latch req_pc=fetch_pc, fetch_pc += INSTR_W/8 (wraps modulo 2^ADDR_W), -> WAIT. Else stay REQ (full, no request).
- WAIT: on mem_rvalid: if discard=0 push {mem_rdata, req_pc}; clear discard; -> REQ. At most one read outstanding.
- Pop: instr_valid=1 and instr_ready=1 removes head. Push and pop same cycle: count unchanged; legal when full (space reserved at issue, so push never overflows).
- Redirect (highest priority): queue emptied, fetch_pc=redirect_pc; if in WAIT and mem_rvalid not this cycle, set discard=1 and stay WAIT; else -> REQ (IDLE if en=0). Response arriving in the redirect cycle is dropped. Pop in the redirect cycle ignored.
- en low mid-WAIT: response still accepted, then IDLE.
- count is log2(DEPTH)+1 bits; read/write pointers wrap modulo DEPTH.

## Timing
- mem_req to earliest push: 1 cycle after mem_rvalid (registered queue write); instr_valid rises the cycle after mem_rvalid.
- Back-to-back with 1-cycle memory: one request every 2 cycles (REQ, WAIT).
- Redirect at edge N: instr_valid=0 from N+1; first new mem_req at N+1 if no read was outstanding, otherwise the cycle after the stale response.
- Outputs registered except instr_valid/instr/instr_pc, which are the queue head (registered storage, no combinational input path).

## Configuration
- FETCH_BYPASS_EN defined: when the queue is empty, discard=0, no redirect and mem_rvalid=1, mem_rdata/req_pc drive instr/instr_pc combinationally with instr_valid=1; if instr_ready=1 same cycle the entry is not written. Zero-cycle fetch-to-decode latency.
- Undefined: no combinational path from mem_* to instr_*; always one cycle through the queue.

## Structure
- Shared package fetch_pkg: state enum (IDLE, REQ, WAIT), queue entry struct {instr, pc}, PC step constant.
- One sub-module: fetch_fifo (DEPTH entries, push/pop/flush, count, full/empty); FSM and PC logic in fetch_queue.

## Test plan
- Reset, en=1, 1-cycle memory returning addr+0x100, instr_ready=1 -> mem_addr 0,4,8,...; instr_pc 0,4,8 with instr 0x100,0x104,0x108 in order.
- instr_ready=0, DEPTH=4 -> exactly 4 requests, then mem_req held low; raise ready -> 4 pops, fetching resumes at 0x10.
- Redirect to 0x200 while read of 0x8 outstanding -> stale response dropped, queue empty, next mem_addr 0x200, next instr_pc 0x200.
- Redirect same cycle as mem_rvalid -> that data never appears; next request 0x200 the following cycle.
- Full queue with simultaneous pop and push -> count stays 4, order preserved.
- rst_n pulsed low mid-WAIT -> all outputs 0 immediately; late mem_rvalid ignored; restart fetches RESET_PC.
